// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU op codes, mux-select encodings and branch funct3.
// Imported by the decode/execute slice and its ALU.
package rv_pkg;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluSll   = 4'd2;
  localparam logic [3:0] AluSlt   = 4'd3;
  localparam logic [3:0] AluSltu  = 4'd4;
  localparam logic [3:0] AluXor   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluOr    = 4'd8;
  localparam logic [3:0] AluAnd   = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  localparam logic [1:0] WbPcPlus4 = 2'd0;
  localparam logic [1:0] WbAlu     = 2'd1;
  localparam logic [1:0] WbDm      = 2'd2;

  localparam logic PcPlus4 = 1'b0;
  localparam logic PcAlu   = 1'b1;
  localparam logic OpAPc   = 1'b0;
  localparam logic OpARs1  = 1'b1;
  localparam logic OpBRs2  = 1'b0;
  localparam logic OpBImm  = 1'b1;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  // alt selects SUB/SRA over ADD/SRL; callers must only set it where that is legal.
  function automatic logic [3:0] alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_data_memory_decode_control_if.sv
// Bus between the core (fetch/PC/register file) and the decode/execute slice.
// master = core side, slave = decode/execute slice.
interface alu_data_memory_decode_control_if;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rf_sel_1;
  logic [4:0]  rf_sel_2;
  logic [4:0]  rf_sel_rd;
  logic        rf_wr_en;
  logic [1:0]  rf_data_in_mux_sel;
  logic        pc_in_mux_sel;
  logic        alu_op_1_mux_sel;
  logic        alu_op_2_mux_sel;
  logic [3:0]  alu_opcode;
  logic [31:0] immediate;
  logic        dm_wr_en;
  logic [31:0] alu_out;
  logic [31:0] dm_data_out;
  logic        illegal;

  modport master (
    output instruction, pc, pc_plus4, rs1_data, rs2_data,
    input  rf_sel_1, rf_sel_2, rf_sel_rd, rf_wr_en, rf_data_in_mux_sel, pc_in_mux_sel,
           alu_op_1_mux_sel, alu_op_2_mux_sel, alu_opcode, immediate, dm_wr_en, alu_out,
           dm_data_out, illegal
  );

  modport slave (
    input  instruction, pc, pc_plus4, rs1_data, rs2_data,
    output rf_sel_1, rf_sel_2, rf_sel_rd, rf_wr_en, rf_data_in_mux_sel, pc_in_mux_sel,
           alu_op_1_mux_sel, alu_op_2_mux_sel, alu_opcode, immediate, dm_wr_en, alu_out,
           dm_data_out, illegal
  );
endinterface

// File: rtl/alu.sv
// Combinational RV32I ALU; arithmetic wraps, shifts use b[4:0], unknown op codes add.
module alu
  import rv_pkg::*;
(
  input  logic [3:0]  opcode_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  always_comb begin
    y_o = a_i + b_i;
    case (opcode_i)
      AluSub:   y_o = a_i - b_i;
      AluSll:   y_o = a_i << b_i[4:0];
      AluSlt:   y_o = {31'd0, $signed(a_i) < $signed(b_i)};
      AluSltu:  y_o = {31'd0, a_i < b_i};
      AluXor:   y_o = a_i ^ b_i;
      AluSrl:   y_o = a_i >> b_i[4:0];
      AluSra:   y_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      AluOr:    y_o = a_i | b_i;
      AluAnd:   y_o = a_i & b_i;
      AluPassB: y_o = b_i;
      default:  y_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Word-addressed data RAM: combinational read, write on rising clock edge, no reset of contents.
module data_memory #(
  parameter int unsigned DM_DEPTH  = 1024,
  parameter int unsigned DM_ADDR_W = 10
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [DM_ADDR_W-1:0] addr_i,
  input  logic [31:0]          wr_data_i,
  output logic [31:0]          rd_data_o
);

  logic [31:0] mem_q [DM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/alu_data_memory_decode_control.sv
// Single-cycle RV32I decode/execute slice: instruction decode, operand muxes, ALU, branch
// comparator and data RAM. Only the RAM write is clocked.
module alu_data_memory_decode_control
  import rv_pkg::*;
#(
  parameter int unsigned DM_DEPTH  = 1024,
  parameter int unsigned DM_ADDR_W = 10
) (
  input logic                            clock,
  input logic                            reset,
  alu_data_memory_decode_control_if.slave bus
);

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;

  assign instr     = bus.instruction;
  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u     = {instr[31:12], 12'd0};
  assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_shamt = {27'd0, instr[24:20]};

  logic        legal, dec_rf_we, dec_dm_we, jump, is_jalr, is_branch;
  logic [1:0]  wb_sel;
  logic        op_a_sel, op_b_sel;
  logic [3:0]  alu_op;
  logic [31:0] imm;

  always_comb begin
    legal     = 1'b0;
    dec_rf_we = 1'b0;
    dec_dm_we = 1'b0;
    jump      = 1'b0;
    is_jalr   = 1'b0;
    is_branch = 1'b0;
    wb_sel    = WbAlu;
    op_a_sel  = OpARs1;
    op_b_sel  = OpBImm;
    alu_op    = AluAdd;
    imm       = imm_i;
    case (opcode)
      OpcLui: begin
        legal     = 1'b1;
        dec_rf_we = 1'b1;
        alu_op    = AluPassB;
        imm       = imm_u;
      end
      OpcAuipc: begin
        legal     = 1'b1;
        dec_rf_we = 1'b1;
        op_a_sel  = OpAPc;
        imm       = imm_u;
      end
      OpcJal: begin
        legal     = 1'b1;
        dec_rf_we = 1'b1;
        jump      = 1'b1;
        wb_sel    = WbPcPlus4;
        op_a_sel  = OpAPc;
        imm       = imm_j;
      end
      OpcJalr: begin
        legal     = (funct3 == 3'b000);
        dec_rf_we = 1'b1;
        jump      = 1'b1;
        is_jalr   = 1'b1;
        wb_sel    = WbPcPlus4;
      end
      OpcBranch: begin
        legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
        is_branch = 1'b1;
        op_a_sel  = OpAPc;
        imm       = imm_b;
      end
      OpcLoad: begin
        legal     = (funct3 == 3'b010);
        dec_rf_we = 1'b1;
        wb_sel    = WbDm;
      end
      OpcStore: begin
        legal     = (funct3 == 3'b010);
        dec_dm_we = 1'b1;
        imm       = imm_s;
      end
      OpcOpImm: begin
        // Only the shift forms constrain funct7; SRAI is the sole alternate encoding.
        if (funct3 == 3'b001) begin
          legal = (funct7 == F7Base);
        end else if (funct3 == 3'b101) begin
          legal = (funct7 == F7Base) || (funct7 == F7Alt);
        end else begin
          legal = 1'b1;
        end
        dec_rf_we = 1'b1;
        alu_op    = alu_op_from_funct3(funct3, (funct3 == 3'b101) && instr[30]);
        imm       = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? imm_shamt : imm_i;
      end
      OpcOp: begin
        legal     = (funct7 == F7Base) ||
                    ((funct7 == F7Alt) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec_rf_we = 1'b1;
        op_b_sel  = OpBRs2;
        alu_op    = alu_op_from_funct3(funct3, instr[30]);
        imm       = 32'd0;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec_rf_we = 1'b0;
      dec_dm_we = 1'b0;
      jump      = 1'b0;
      is_jalr   = 1'b0;
      is_branch = 1'b0;
      wb_sel    = WbPcPlus4;
      op_a_sel  = OpAPc;
      op_b_sel  = OpBRs2;
      alu_op    = AluAdd;
      imm       = 32'd0;
    end
  end

  // Branch decisions use their own comparator so the ALU is free to form the target.
  logic br_eq, br_lt, br_ltu, br_cond;
  assign br_eq  = (bus.rs1_data == bus.rs2_data);
  assign br_lt  = ($signed(bus.rs1_data) < $signed(bus.rs2_data));
  assign br_ltu = (bus.rs1_data < bus.rs2_data);

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      F3Beq:   br_cond = br_eq;
      F3Bne:   br_cond = !br_eq;
      F3Blt:   br_cond = br_lt;
      F3Bge:   br_cond = !br_lt;
      F3Bltu:  br_cond = br_ltu;
      F3Bgeu:  br_cond = !br_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  logic [31:0] op_a, op_b, alu_y, alu_res;
  assign op_a    = (op_a_sel == OpARs1) ? bus.rs1_data : bus.pc;
  assign op_b    = (op_b_sel == OpBImm) ? imm : bus.rs2_data;
  assign alu_res = is_jalr ? {alu_y[31:1], 1'b0} : alu_y;

  alu u_alu (
    .opcode_i (alu_op),
    .a_i      (op_a),
    .b_i      (op_b),
    .y_o      (alu_y)
  );

  logic dm_we;
  assign dm_we = dec_dm_we && !reset;

  data_memory #(
    .DM_DEPTH  (DM_DEPTH),
    .DM_ADDR_W (DM_ADDR_W)
  ) u_data_memory (
    .clk_i     (clock),
    .wr_en_i   (dm_we),
    .addr_i    (alu_res[DM_ADDR_W+1:2]),
    .wr_data_i (bus.rs2_data),
    .rd_data_o (bus.dm_data_out)
  );

  assign bus.rf_sel_1           = instr[19:15];
  assign bus.rf_sel_2           = instr[24:20];
  assign bus.rf_sel_rd          = instr[11:7];
  assign bus.rf_wr_en           = dec_rf_we && (instr[11:7] != 5'd0) && !reset;
  assign bus.rf_data_in_mux_sel = wb_sel;
  assign bus.pc_in_mux_sel      = (jump || (is_branch && br_cond)) && !reset ? PcAlu : PcPlus4;
  assign bus.alu_op_1_mux_sel   = op_a_sel;
  assign bus.alu_op_2_mux_sel   = op_b_sel;
  assign bus.alu_opcode         = alu_op;
  assign bus.immediate          = imm;
  assign bus.dm_wr_en           = dm_we;
  assign bus.alu_out            = alu_res;
  assign bus.illegal            = !legal && !reset;

endmodule

// File: tb/tb_alu_data_memory_decode_control.sv
// Scoreboard bench: directed vectors push hand-computed expectations; a negedge monitor pops
// and compares against the DUT outputs for the same cycle.
module tb_alu_data_memory_decode_control;

  logic clock = 1'b0;
  logic reset;

  alu_data_memory_decode_control_if bus ();

  alu_data_memory_decode_control #(
    .DM_DEPTH  (1024),
    .DM_ADDR_W (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        rf_we;
    logic        dm_we;
    logic        pc_sel;
    logic        ill;
    logic        chk_wb;
    logic [1:0]  wb;
    logic        chk_alu;
    logic [31:0] alu;
    logic        chk_dm;
    logic [31:0] dm;
    logic        chk_rd;
    logic [4:0]  rd;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  exp_t  mon_e;
  string mon_n;

  // wb/rd < 0 means "don't check"; chk_alu/chk_dm gate the data comparisons.
  function automatic exp_t mk(input logic rf_we, input logic dm_we, input logic pc_sel,
                              input logic ill, input int wb, input logic chk_alu,
                              input logic [31:0] alu, input logic chk_dm,
                              input logic [31:0] dm, input int rd);
    exp_t e;
    e.rf_we   = rf_we;
    e.dm_we   = dm_we;
    e.pc_sel  = pc_sel;
    e.ill     = ill;
    e.chk_wb  = (wb >= 0);
    e.wb      = 2'(wb);
    e.chk_alu = chk_alu;
    e.alu     = alu;
    e.chk_dm  = chk_dm;
    e.dm      = dm;
    e.chk_rd  = (rd >= 0);
    e.rd      = 5'(rd);
    return e;
  endfunction

  task automatic chk(input string n, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", n, f, act, exp);
    end
  endtask

  task automatic drive(input string n, input logic rst, input logic [31:0] instr,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input exp_t e);
    @(posedge clock);
    #1;
    reset           = rst;
    bus.instruction = instr;
    bus.pc          = pc;
    bus.pc_plus4    = pc + 32'd4;
    bus.rs1_data    = rs1;
    bus.rs2_data    = rs2;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      chk(mon_n, "rf_wr_en", {31'd0, bus.rf_wr_en}, {31'd0, mon_e.rf_we});
      chk(mon_n, "dm_wr_en", {31'd0, bus.dm_wr_en}, {31'd0, mon_e.dm_we});
      chk(mon_n, "pc_in_mux_sel", {31'd0, bus.pc_in_mux_sel}, {31'd0, mon_e.pc_sel});
      chk(mon_n, "illegal", {31'd0, bus.illegal}, {31'd0, mon_e.ill});
      if (mon_e.chk_wb)
        chk(mon_n, "rf_data_in_mux_sel", {30'd0, bus.rf_data_in_mux_sel}, {30'd0, mon_e.wb});
      if (mon_e.chk_alu) chk(mon_n, "alu_out", bus.alu_out, mon_e.alu);
      if (mon_e.chk_dm) chk(mon_n, "dm_data_out", bus.dm_data_out, mon_e.dm);
      if (mon_e.chk_rd) chk(mon_n, "rf_sel_rd", {27'd0, bus.rf_sel_rd}, {27'd0, mon_e.rd});
    end
  end

  initial begin
    reset           = 1'b1;
    bus.instruction = 32'd0;
    bus.pc          = 32'd0;
    bus.pc_plus4    = 32'd4;
    bus.rs1_data    = 32'd0;
    bus.rs2_data    = 32'd0;

    // Reset holds every write/redirect off but decode still runs.
    drive("rst_addi", 1, 32'hFFD00293, 32'h40, 32'h0, 32'h0,
          mk(0, 0, 0, 0, 1, 1, 32'hFFFFFFFD, 0, 0, 5));
    drive("rst_zero", 1, 32'h00000000, 32'h40, 32'h0, 32'h0,
          mk(0, 0, 0, 0, -1, 0, 0, 0, 0, -1));
    drive("rst_jal", 1, 32'h008000EF, 32'h40, 32'h0, 32'h0,
          mk(0, 0, 0, 0, 0, 1, 32'h48, 0, 0, 1));

    drive("addi", 0, 32'hFFD00293, 32'h40, 32'h0, 32'h0,
          mk(1, 0, 0, 0, 1, 1, 32'hFFFFFFFD, 0, 0, 5));
    drive("addi_x0", 0, 32'h00500013, 32'h40, 32'h0, 32'h0,
          mk(0, 0, 0, 0, 1, 1, 32'h5, 0, 0, 0));

    // Memory: write, overwrite (old data visible until the edge), read back.
    drive("sw_first", 0, 32'h0020A423, 32'h40, 32'h100, 32'h11111111,
          mk(0, 1, 0, 0, 1, 1, 32'h108, 0, 0, -1));
    drive("sw_second", 0, 32'h0020A423, 32'h40, 32'h100, 32'hDEADBEEF,
          mk(0, 1, 0, 0, 1, 1, 32'h108, 1, 32'h11111111, -1));
    drive("lw", 0, 32'h0080A183, 32'h40, 32'h100, 32'h0,
          mk(1, 0, 0, 0, 2, 1, 32'h108, 1, 32'hDEADBEEF, 3));
    drive("rst_sw", 1, 32'h0020A423, 32'h40, 32'h100, 32'hCAFEF00D,
          mk(0, 0, 0, 0, 1, 1, 32'h108, 1, 32'hDEADBEEF, -1));
    drive("lw_wrap", 0, 32'h0080A183, 32'h40, 32'h1101, 32'h0,
          mk(1, 0, 0, 0, 2, 1, 32'h1109, 1, 32'hDEADBEEF, 3));

    drive("beq_taken", 0, 32'h00208863, 32'h40, 32'h7, 32'h7,
          mk(0, 0, 1, 0, -1, 1, 32'h50, 0, 0, -1));
    drive("beq_not", 0, 32'h00208863, 32'h40, 32'h7, 32'h8,
          mk(0, 0, 0, 0, -1, 1, 32'h50, 0, 0, -1));
    drive("blt_signed", 0, 32'h0020C863, 32'h40, 32'hFFFFFFFF, 32'h1,
          mk(0, 0, 1, 0, -1, 1, 32'h50, 0, 0, -1));
    drive("bltu_not", 0, 32'h0020E863, 32'h40, 32'hFFFFFFFF, 32'h1,
          mk(0, 0, 0, 0, -1, 1, 32'h50, 0, 0, -1));

    drive("jalr", 0, 32'h000300E7, 32'h40, 32'h203, 32'h0,
          mk(1, 0, 1, 0, 0, 1, 32'h202, 0, 0, 1));
    drive("jal", 0, 32'h008000EF, 32'h40, 32'h0, 32'h0,
          mk(1, 0, 1, 0, 0, 1, 32'h48, 0, 0, 1));

    drive("sra", 0, 32'h4020D3B3, 32'h40, 32'h80000000, 32'h4,
          mk(1, 0, 0, 0, 1, 1, 32'hF8000000, 0, 0, 7));
    drive("srai", 0, 32'h4040D193, 32'h40, 32'h80000000, 32'h0,
          mk(1, 0, 0, 0, 1, 1, 32'hF8000000, 0, 0, 3));
    drive("sltu", 0, 32'h0020B3B3, 32'h40, 32'h1, 32'hFFFFFFFF,
          mk(1, 0, 0, 0, 1, 1, 32'h1, 0, 0, 7));
    drive("sub", 0, 32'h402081B3, 32'h40, 32'h5, 32'h7,
          mk(1, 0, 0, 0, 1, 1, 32'hFFFFFFFE, 0, 0, 3));
    drive("lui", 0, 32'h12345237, 32'h40, 32'h0, 32'h0,
          mk(1, 0, 0, 0, 1, 1, 32'h12345000, 0, 0, 4));
    drive("auipc", 0, 32'h00001217, 32'h40, 32'h0, 32'h0,
          mk(1, 0, 0, 0, 1, 1, 32'h1040, 0, 0, 4));

    // Illegal: selects 0 and ADD, so the ALU sees pc + rs2.
    drive("illegal_zero", 0, 32'h00000000, 32'h100, 32'h0, 32'h20,
          mk(0, 0, 0, 1, 0, 1, 32'h120, 0, 0, -1));
    drive("illegal_mul", 0, 32'h022081B3, 32'h40, 32'h5, 32'h7,
          mk(0, 0, 0, 1, 0, 0, 0, 0, 0, -1));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
